reg_writeback: RTL and testbench

//  Write-side master for the 8-bit register file: collects ALU results, data-memory load

---
 rtl/reg_wb_pkg.sv | 41 ++++
 rtl/wb_queue.sv | 83 ++++++++
 rtl/reg_writeback.sv | 207 ++++++++++++++++++++
 tb/tb_reg_writeback.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_pkg
//  Description : Shared types for the register-file write-back master: the
//                pending-write entry, the occupancy state encoding and the
//                default sizing constants.
//  Contents    : wb_entry_t   {addr, data} pending RF write
//                wb_state_t   WB_IDLE / WB_BUSY / WB_STALL
//                wb_state_for occupancy -> state mapping
//  Revision    : 1.0  initial release
// ============================================================================
package reg_wb_pkg;

  localparam int WB_DEFAULT_DEPTH = 4;
  localparam int WB_DEFAULT_PW    = 4;
  // Entry address field is sized for the widest supported register file;
  // narrower instances zero-extend into it.
  localparam int WB_MAX_PW        = 8;

  typedef struct packed {
    logic [WB_MAX_PW-1:0] addr;
    logic [7:0]           data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_BUSY  = 2'd1,
    WB_STALL = 2'd2
  } wb_state_t;

  // Stall as soon as only one slot is left so a request already in flight
  // from upstream still fits.
  function automatic wb_state_t wb_state_for(input int unsigned count,
                                             input int unsigned depth);
    if (count == 0)              return WB_IDLE;
    else if (count >= depth - 1) return WB_STALL;
    else                         return WB_BUSY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_queue
//  Description : DEPTH-entry circular FIFO of pending RF writes. Two ordered
//                push ports (push1 only honoured together with push0), one
//                pop, and every slot plus its valid bit exposed for hazard
//                and forwarding search.
//  Ports       : clk, reset         clock, synchronous active-high reset
//                push0/push0_entry  first (older) entry to enqueue
//                push1/push1_entry  second (younger) entry to enqueue
//                pop                drop the head entry
//                head               oldest entry
//                count              occupancy 0..DEPTH
//                rd_ptr             slot index of the head
//                entries/valid      raw slot contents and occupancy bits
//  Revision    : 1.0  initial release
// ============================================================================
module wb_queue
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push0,
  input  wb_entry_t                push0_entry,
  input  logic                     push1,
  input  wb_entry_t                push1_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output wb_entry_t                entries [DEPTH],
  output logic [DEPTH-1:0]         valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    w_wr_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + 1'b1;

  // The caller never pushes into an occupied slot, so a pop and a push in
  // the same cycle always touch different slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (push0) begin
        r_mem[r_wr_ptr]   <= push0_entry;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (push0 && push1) begin
        r_mem[w_wr_ptr1]   <= push1_entry;
        r_valid[w_wr_ptr1] <= 1'b1;
      end
      if (push0 && push1) r_wr_ptr <= w_wr_ptr1 + 1'b1;
      else if (push0)     r_wr_ptr <= w_wr_ptr1;
      r_count <= r_count + CW'(push0) + CW'(push0 & push1) - CW'(pop);
    end
  end

  assign head    = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign rd_ptr  = r_rd_ptr;
  assign entries = r_mem;
  assign valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback
//  Description : Write-side master of the 8-bit register file. Orders ALU
//                results, register moves and load returns onto the single RF
//                write port. Loads always win the port; ALU/move requests
//                bypass straight to the port when nothing is pending,
//                otherwise they wait in a small FIFO.
//  Ports       : clk, reset                 clock, sync active-high reset
//                alu_valid/addr/data        ALU result
//                mv_valid/dst/src           register move request
//                rf_rd_addr/rf_rd_data      RF read port used by moves
//                ld_valid/addr/data         load return (never queued)
//                wr_en/wr_addr/wr_data      registered RF write port
//                stall                      upstream hold (registered)
//                overflow                   sticky request-dropped flag
//                q_addr/q_hit               hazard query
//                q_fwd_data                 forwarded value (REG_WB_FWD_EN)
//  Config      : REG_WB_FWD_EN adds q_fwd_data.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int pw    = WB_DEFAULT_PW,
  parameter int DEPTH = WB_DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [pw-1:0] alu_addr,
  input  logic [7:0]    alu_data,
  input  logic          mv_valid,
  input  logic [pw-1:0] mv_dst,
  input  logic [pw-1:0] mv_src,
  output logic [pw-1:0] rf_rd_addr,
  input  logic [7:0]    rf_rd_data,
  input  logic          ld_valid,
  input  logic [pw-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          wr_en,
  output logic [pw-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          stall,
  output logic          overflow,
  input  logic [pw-1:0] q_addr,
  output logic          q_hit
`ifdef REG_WB_FWD_EN
  ,
  output logic [7:0]    q_fwd_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t        w_q_head;
  logic [CW-1:0]    w_q_count;
  logic [AW-1:0]    w_q_rd_ptr;
  wb_entry_t        w_q_entries [DEPTH];
  logic [DEPTH-1:0] w_q_valid;
  logic             w_push0, w_push1, w_pop;
  wb_entry_t        w_push0_entry, w_push1_entry;
  wb_entry_t        w_alu_e, w_mv_e, w_c0_e;
  logic             w_c0, w_c1;
  logic [7:0]       w_mv_data;
  logic             w_q_hit;
  logic             w_wr_en_next;
  logic [pw-1:0]    w_wr_addr_next;
  logic [7:0]       w_wr_data_next;
  logic             w_drop;
  logic [CW-1:0]    w_free;
  logic [CW-1:0]    w_count_next;
  wb_state_t        r_state, w_state_next;
  logic             w_unused_head_hi;
`ifdef REG_WB_FWD_EN
  logic [7:0]       w_q_fwd;
`endif

  // Slot index k positions after the head; walking k upward visits entries
  // oldest to newest, so the last match found is the newest.
  function automatic logic [AW-1:0] slot(input logic [AW-1:0] base, input int k);
    return base + AW'(k);
  endfunction

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push0       (w_push0),
    .push0_entry (w_push0_entry),
    .push1       (w_push1),
    .push1_entry (w_push1_entry),
    .pop         (w_pop),
    .head        (w_q_head),
    .count       (w_q_count),
    .rd_ptr      (w_q_rd_ptr),
    .entries     (w_q_entries),
    .valid       (w_q_valid)
  );

  assign rf_rd_addr       = mv_src;
  assign w_alu_e          = {WB_MAX_PW'(alu_addr), alu_data};
  assign w_mv_e           = {WB_MAX_PW'(mv_dst), w_mv_data};
  assign w_free           = CW'(DEPTH) - w_q_count;
  assign w_unused_head_hi = ^w_q_head.addr;

  // Move source value, youngest producer first: a same-cycle ALU result
  // (older in program order), then the newest queued entry, then the write
  // in flight (not yet in the RF), then the RF itself.
  always_comb begin
    w_mv_data = rf_rd_data;
    if (wr_en && (wr_addr == mv_src)) w_mv_data = wr_data;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_q_valid[slot(w_q_rd_ptr, k)] &&
          (w_q_entries[slot(w_q_rd_ptr, k)].addr == WB_MAX_PW'(mv_src)))
        w_mv_data = w_q_entries[slot(w_q_rd_ptr, k)].data;
    end
    if (alu_valid && (alu_addr == mv_src)) w_mv_data = alu_data;
  end

  // Hazard query over the write in flight and every queued entry.
  always_comb begin
    w_q_hit = wr_en && (wr_addr == q_addr);
`ifdef REG_WB_FWD_EN
    w_q_fwd = wr_data;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (w_q_valid[slot(w_q_rd_ptr, k)] &&
          (w_q_entries[slot(w_q_rd_ptr, k)].addr == WB_MAX_PW'(q_addr))) begin
        w_q_hit = 1'b1;
`ifdef REG_WB_FWD_EN
        w_q_fwd = w_q_entries[slot(w_q_rd_ptr, k)].data;
`endif
      end
    end
  end

  assign q_hit = w_q_hit;
`ifdef REG_WB_FWD_EN
  assign q_fwd_data = w_q_hit ? w_q_fwd : 8'h00;
`endif

  // Port arbitration and enqueue. Queue candidates are c0 (older) and c1
  // (younger); free slots are judged on the occupancy before any pop.
  always_comb begin
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = wr_addr;
    w_wr_data_next = wr_data;
    w_pop          = 1'b0;
    w_c0           = alu_valid | mv_valid;
    w_c1           = alu_valid & mv_valid;
    w_c0_e         = alu_valid ? w_alu_e : w_mv_e;
    w_push0        = 1'b0;
    w_push1        = 1'b0;
    w_push0_entry  = w_c0_e;
    w_push1_entry  = w_mv_e;
    w_drop         = 1'b0;
    if (ld_valid) begin
      w_wr_en_next   = 1'b1;
      w_wr_addr_next = ld_addr;
      w_wr_data_next = ld_data;
    end else if (w_q_count != '0) begin
      w_wr_en_next   = 1'b1;
      w_wr_addr_next = w_q_head.addr[pw-1:0];
      w_wr_data_next = w_q_head.data;
      w_pop          = 1'b1;
    end else if (w_c0) begin
      // Empty queue: the first request skips the queue; a second one (the
      // move) becomes the only queue candidate.
      w_wr_en_next   = 1'b1;
      w_wr_addr_next = w_c0_e.addr[pw-1:0];
      w_wr_data_next = w_c0_e.data;
      w_c0           = w_c1;
      w_c0_e         = w_mv_e;
      w_c1           = 1'b0;
    end
    w_push0       = w_c0 && (w_free >= CW'(1));
    w_push1       = w_c1 && (w_free >= CW'(2));
    w_push0_entry = w_c0_e;
    w_push1_entry = w_mv_e;
    w_drop        = (w_c0 && !w_push0) || (w_c1 && !w_push1);
  end

  assign w_count_next = w_q_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
  assign w_state_next = wb_state_for(32'(w_count_next), DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= WB_IDLE;
      overflow <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      r_state  <= w_state_next;
      overflow <= overflow | w_drop;
      wr_en    <= w_wr_en_next;
      wr_addr  <= w_wr_addr_next;
      wr_data  <= w_wr_data_next;
    end
  end

  // Straight decode of the state register; changes only on clock edges.
  assign stall = (r_state == WB_STALL);

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_writeback
//  Description : Self-checking bench for reg_writeback. A stimulus process
//                drives directed and random cycles and feeds a reference
//                model of the write ordering; expected RF writes go into a
//                scoreboard queue that a negedge monitor drains.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_writeback;
  import reg_wb_pkg::*;

  localparam int PW    = 4;
  localparam int DEPTH = 4;
  localparam int NREG  = 1 << PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mv_valid, ld_valid;
  logic [PW-1:0] alu_addr, mv_dst, mv_src, ld_addr, q_addr, rf_rd_addr;
  logic [7:0]    alu_data, ld_data, rf_rd_data;
  logic          wr_en, stall, overflow, q_hit;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
`ifdef REG_WB_FWD_EN
  logic [7:0]    q_fwd_data;
`endif

  always #5 clk = ~clk;

  reg_writeback #(.pw(PW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mv_valid   (mv_valid),
    .mv_dst     (mv_dst),
    .mv_src     (mv_src),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .stall      (stall),
    .overflow   (overflow),
    .q_addr     (q_addr),
    .q_hit      (q_hit)
`ifdef REG_WB_FWD_EN
    ,
    .q_fwd_data (q_fwd_data)
`endif
  );

  // Register file environment
  logic [7:0] rf [NREG] = '{default: 8'h00};
  assign rf_rd_data = rf[rf_rd_addr];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  typedef struct { logic [PW-1:0] addr; logic [7:0] data; } ent_t;
  typedef struct { logic [PW-1:0] addr; logic [7:0] data; int cyc; } exp_t;
  exp_t       exp_q[$];
  ent_t       pend[$];
  logic [7:0] arch [NREG] = '{default: 8'h00};  // value each reg holds once all accepted writes land
  logic [7:0] mrf  [NREG] = '{default: 8'h00};  // value after writes already granted the port
  logic       infl_v = 1'b0;
  ent_t       infl;
  logic       m_stall = 1'b0, m_ovf = 1'b0;
  logic       exp_valid = 1'b0;
  logic       e_stall, e_ovf, e_qhit;
`ifdef REG_WB_FWD_EN
  logic [7:0] e_qfwd;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic emit(input logic [PW-1:0] a, input logic [7:0] d);
    exp_t x;
    x.addr = a; x.data = d; x.cyc = cyc + 1;
    exp_q.push_back(x);
    mrf[a] = d;
    infl_v = 1'b1; infl.addr = a; infl.data = d;
  endtask

  task automatic step(input logic rs,
                      input logic av, input logic [PW-1:0] aa, input logic [7:0] ad,
                      input logic mvv, input logic [PW-1:0] md, input logic [PW-1:0] ms,
                      input logic lv, input logic [PW-1:0] la, input logic [7:0] ldd,
                      input logic [PW-1:0] qa);
    ent_t reqs[$];
    ent_t e;
    logic [7:0] mvval;
    bit was_empty, ld_pending;
    int free;
    @(posedge clk); #1;
    reset = rs; alu_valid = av; alu_addr = aa; alu_data = ad;
    mv_valid = mvv; mv_dst = md; mv_src = ms;
    ld_valid = lv; ld_addr = la; ld_data = ldd; q_addr = qa;
    // Expectations for this cycle come from the state left by the last one.
    e_stall = m_stall;
    e_ovf   = m_ovf;
    e_qhit  = infl_v && (infl.addr == qa);
`ifdef REG_WB_FWD_EN
    e_qfwd  = e_qhit ? infl.data : 8'h00;
`endif
    foreach (pend[i]) if (pend[i].addr == qa) begin
      e_qhit = 1'b1;
`ifdef REG_WB_FWD_EN
      e_qfwd = pend[i].data;
`endif
    end
    exp_valid = 1'b1;
    infl_v = 1'b0;
    if (rs) begin
      pend.delete();
      m_stall = 1'b0;
      m_ovf   = 1'b0;
      arch    = mrf;
      return;
    end
    mvval = (av && (aa == ms)) ? ad : arch[ms];
    ld_pending = 1'b0;
    foreach (pend[i]) if (pend[i].addr == la) ld_pending = 1'b1;
    free = DEPTH - pend.size();
    was_empty = (pend.size() == 0);
    if (av)  begin e.addr = aa; e.data = ad;    reqs.push_back(e); end
    if (mvv) begin e.addr = md; e.data = mvval; reqs.push_back(e); end
    if (lv) begin
      emit(la, ldd);
      if (!ld_pending) arch[la] = ldd;
    end else if (!was_empty) begin
      e = pend.pop_front();
      emit(e.addr, e.data);
    end else if (reqs.size() > 0) begin
      e = reqs.pop_front();
      emit(e.addr, e.data);
      arch[e.addr] = e.data;
    end
    foreach (reqs[i]) begin
      if (free > 0) begin
        pend.push_back(reqs[i]);
        arch[reqs[i].addr] = reqs[i].data;
        free--;
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_stall = (pend.size() >= DEPTH - 1);
  endtask

  task automatic idle(input logic [PW-1:0] qa);
    step(1'b0, 1'b0, '0, 8'h00, 1'b0, '0, '0, 1'b0, '0, 8'h00, qa);
  endtask

  // Monitor / scoreboard
  exp_t mon_x;
  logic mon_we;
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("q_hit", 32'(q_hit), 32'(e_qhit));
`ifdef REG_WB_FWD_EN
      chk("q_fwd_data", 32'(q_fwd_data), 32'(e_qfwd));
`endif
      mon_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("wr_en", 32'(wr_en), 32'(mon_we));
      if (mon_we) begin
        mon_x = exp_q.pop_front();
        if (wr_en) begin
          chk("wr_addr", 32'(wr_addr), 32'(mon_x.addr));
          chk("wr_data", 32'(wr_data), 32'(mon_x.data));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; alu_valid = 1'b0; mv_valid = 1'b0; ld_valid = 1'b0;
    alu_addr = '0; alu_data = '0; mv_dst = '0; mv_src = '0;
    ld_addr = '0; ld_data = '0; q_addr = '0;
    repeat (2) @(posedge clk);

    // ALU r3 <= 5A alone, empty queue: bypass, written next cycle
    step(0, 1, 4'd3, 8'h5A, 0, '0, '0, 0, '0, 8'h00, 4'd3);
    idle(4'd3);
    idle(4'd3);
    // load r1 and ALU r2 together: r1 then r2
    step(0, 1, 4'd2, 8'h22, 0, '0, '0, 1, 4'd1, 8'h11, 4'd2);
    idle(4'd2);
    idle(4'd1);
    // ALU r4 <= 77, then move r5 <= r4 while loads hold the port
    step(0, 1, 4'd4, 8'h77, 0, '0, '0, 1, 4'd9, 8'hAA, 4'd4);
    step(0, 0, '0, 8'h00, 1, 4'd5, 4'd4, 1, 4'd9, 8'hBB, 4'd5);
    repeat (3) idle(4'd5);
    // queued r6 <= 3C visible to the hazard query
    step(0, 1, 4'd6, 8'h3C, 0, '0, '0, 1, 4'd8, 8'h01, 4'd6);
    step(0, 0, '0, 8'h00, 0, '0, '0, 1, 4'd8, 8'h02, 4'd6);
    repeat (3) idle(4'd6);
    // load held while ALU writes pile up: stall, then drop and overflow
    for (int i = 0; i < 5; i++)
      step(0, 1, 4'(7 + i), 8'(8'h40 + i), 0, '0, '0, 1, 4'd15, 8'(8'h90 + i), 4'(7 + i));
    repeat (6) idle(4'd7);
    // reset with three entries queued: nothing queued reaches the RF
    for (int i = 0; i < 3; i++)
      step(0, 1, 4'(2 + i), 8'(8'hC0 + i), 0, '0, '0, 1, 4'd1, 8'(8'hE0 + i), 4'd2);
    step(1, 0, '0, 8'h00, 0, '0, '0, 0, '0, 8'h00, 4'd2);
    repeat (3) idle(4'd2);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic rs, av, mvv, lv;
      rs  = ($urandom_range(149) == 0);
      av  = 1'($urandom_range(1));
      mvv = ($urandom_range(9) < 4);
      lv  = ($urandom_range(2) == 0);
      if (m_stall && ($urandom_range(7) != 0)) begin av = 1'b0; mvv = 1'b0; end
      if (rs) begin av = 1'b0; mvv = 1'b0; lv = 1'b0; end
      step(rs, av, 4'($urandom_range(15)), 8'($urandom),
           mvv, 4'($urandom_range(15)), 4'($urandom_range(15)),
           lv, 4'($urandom_range(15)), 8'($urandom), 4'($urandom_range(15)));
    end
    repeat (DEPTH + 4) idle(4'd0);
    @(negedge clk); #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d writes outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
